// File: rtl/spm_ctrl_if.sv
// spm_ctrl_if: operand and product valid/ready bundle for spm_ctrl.
// slave = controller side (spm_ctrl); master = producer/consumer side.
interface spm_ctrl_if #(
    parameter int SIZE = 32
);
    logic                in_valid;
    logic                in_ready;
    logic [SIZE-1:0]     in_x;
    logic [SIZE-1:0]     in_y;
    logic                out_valid;
    logic                out_ready;
    logic [2*SIZE-1:0]   out_p;

    modport master (
        output in_valid, in_x, in_y, out_ready,
        input  in_ready, out_valid, out_p
    );

    modport slave (
        input  in_valid, in_x, in_y, out_ready,
        output in_ready, out_valid, out_p
    );
endinterface

// File: rtl/spm_ctrl.sv
// spm_ctrl: sequencer for the spm serial-parallel multiplier.
// Ports: clk, rst (async high); bus (spm_ctrl_if.slave: in_valid/in_ready/
//   in_x/in_y, out_valid/out_ready/out_p); busy_o; spm_x_o, spm_y_o,
//   spm_rst_o to the spm; spm_p_i serial product bit from the spm.
module spm_ctrl #(
    parameter int SIZE = 32
) (
    input  logic            clk,
    input  logic            rst,
    spm_ctrl_if.slave       bus,
    output logic            busy_o,
    output logic [SIZE-1:0] spm_x_o,
    output logic            spm_y_o,
    output logic            spm_rst_o,
    input  logic            spm_p_i
);
    localparam int CNT_W = $clog2(2*SIZE+1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(2*SIZE-1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DRAIN,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SIZE-1:0]     x_q, x_d;
    logic [SIZE-1:0]     y_q, y_d;
    logic [2*SIZE-1:0]   cap_q, cap_d;
    logic [2*SIZE-1:0]   p_q, p_d;
    logic                ov_q, ov_d;
    logic                srst_q, srst_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            cap_q   <= '0;
            p_q     <= '0;
            ov_q    <= 1'b0;
            srst_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cap_q   <= cap_d;
            p_q     <= p_d;
            ov_q    <= ov_d;
            srst_q  <= srst_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        cap_d   = cap_q;
        p_d     = p_q;
        ov_d    = ov_q;
        srst_d  = srst_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    x_d     = bus.in_x;
                    y_d     = bus.in_y;
                    srst_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Arithmetic shift sign-extends y past its top bit.
                y_d   = {y_q[SIZE-1], y_q[SIZE-1:1]};
                cnt_d = cnt_q + 1'b1;
                // spm_p lags y by one cycle; cycle 0 carries no product bit.
                if (cnt_q != '0) begin
                    cap_d = {spm_p_i, cap_q[2*SIZE-1:1]};
                end
                if (cnt_q == LAST) begin
                    // Zero y so spm_y is 0 in DRAIN and while idle.
                    y_d     = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                p_d     = {spm_p_i, cap_q[2*SIZE-1:1]};
                ov_d    = 1'b1;
                srst_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    ov_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = ov_q;
    assign bus.out_p     = p_q;
    assign busy_o        = (state_q == SHIFT) || (state_q == DRAIN);
    assign spm_x_o       = x_q;
    assign spm_y_o       = y_q[0];
    assign spm_rst_o     = srst_q;
endmodule

// File: tb/tb_spm_ctrl.sv
// tb_spm_ctrl: directed and random checks of spm_ctrl at SIZE=32 and SIZE=4,
// each paired with a behavioural shift-add spm model.
module tb_spm_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spm_ctrl_if #(.SIZE(32)) b32();
    spm_ctrl_if #(.SIZE(4))  b4();

    logic        busy32, busy4;
    logic        srst32, srst4;
    logic        y32, y4;
    logic        p32, p4;
    logic [31:0] x32;
    logic [3:0]  x4;

    spm_ctrl #(.SIZE(32)) u32 (
        .clk(clk), .rst(rst), .bus(b32), .busy_o(busy32),
        .spm_x_o(x32), .spm_y_o(y32), .spm_rst_o(srst32), .spm_p_i(p32)
    );

    spm_ctrl #(.SIZE(4)) u4 (
        .clk(clk), .rst(rst), .bus(b4), .busy_o(busy4),
        .spm_x_o(x4), .spm_y_o(y4), .spm_rst_o(srst4), .spm_p_i(p4)
    );

    // spm model: add x when y bit set, emit LSB, arithmetic shift.
    logic signed [65:0] acc32;
    logic signed [9:0]  acc4;

    always @(posedge clk) begin : m32
        logic signed [65:0] s;
        s = acc32 + (y32 ? {{34{x32[31]}}, x32} : 66'sd0);
        if (srst32) begin
            acc32 <= '0;
            p32   <= 1'b0;
        end else begin
            acc32 <= s >>> 1;
            p32   <= s[0];
        end
    end

    always @(posedge clk) begin : m4
        logic signed [9:0] s;
        s = acc4 + (y4 ? {{6{x4[3]}}, x4} : 10'sd0);
        if (srst4) begin
            acc4 <= '0;
            p4   <= 1'b0;
        end else begin
            acc4 <= s >>> 1;
            p4   <= s[0];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic op32(input logic [31:0] x, input logic [31:0] y,
                        output logic [63:0] p, output int lat,
                        output int bc);
        int n;
        n = 0;
        while (!b32.in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        b32.in_x     = x;
        b32.in_y     = y;
        b32.in_valid = 1'b1;
        @(negedge clk);
        b32.in_valid = 1'b0;
        lat = 0;
        bc  = 0;
        while (!b32.out_valid && lat < 300) begin
            if (busy32) bc++;
            @(negedge clk);
            lat++;
        end
        p = b32.out_p;
        b32.out_ready = 1'b1;
        @(negedge clk);
        b32.out_ready = 1'b0;
    endtask

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [63:0] p;
    } vec_t;

    vec_t tv[9];

    initial begin
        logic [63:0] pv;
        int          lat;
        int          bc;
        int          n;

        tv[0] = '{32'd3, 32'd5, 64'd15};
        tv[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1};
        tv[2] = '{32'd7, -32'sd3, 64'hFFFF_FFFF_FFFF_FFEB};
        tv[3] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        tv[4] = '{32'd0, 32'd1234, 64'd0};
        tv[5] = '{32'd0, 32'hFFFF_FFFF, 64'd0};
        tv[6] = '{32'd12345, -32'sd6789, 64'hFFFF_FFFF_FB01_2863};
        tv[7] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001};
        tv[8] = '{32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000};

        b32.in_valid  = 1'b0;
        b32.in_x      = '0;
        b32.in_y      = '0;
        b32.out_ready = 1'b0;
        b4.in_valid   = 1'b0;
        b4.in_x       = '0;
        b4.in_y       = '0;
        b4.out_ready  = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_in_ready",  64'(b32.in_ready), 64'd1);
        chk("rst_out_valid", 64'(b32.out_valid), 64'd0);
        chk("rst_busy",      64'(busy32), 64'd0);
        chk("rst_out_p",     b32.out_p, 64'd0);
        chk("rst_spm_x",     64'(x32), 64'd0);
        chk("rst_spm_y",     64'(y32), 64'd0);
        chk("rst_spm_rst",   64'(srst32), 64'd1);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            op32(tv[i].x, tv[i].y, pv, lat, bc);
            chk($sformatf("vec%0d_p", i), pv, tv[i].p);
            chk($sformatf("vec%0d_lat", i), 64'(lat), 64'd65);
            chk($sformatf("vec%0d_busy", i), 64'(bc), 64'd65);
        end

        // Stall in DONE with in_valid held high the whole time.
        b32.in_x     = 32'd100;
        b32.in_y     = -32'sd7;
        b32.in_valid = 1'b1;
        @(negedge clk);
        b32.in_x = 32'd5;
        b32.in_y = 32'd5;
        n = 0;
        while (!b32.out_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("stall_lat", 64'(n), 64'd65);
        chk("stall_spm_x", 64'(x32), 64'd100);
        pv = b32.out_p;
        chk("stall_p", pv, 64'hFFFF_FFFF_FFFF_FD44);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_hold_p", b32.out_p, pv);
            chk("stall_hold_ov", 64'(b32.out_valid), 64'd1);
            chk("stall_in_ready", 64'(b32.in_ready), 64'd0);
        end
        b32.in_valid  = 1'b0;
        b32.out_ready = 1'b1;
        @(negedge clk);
        b32.out_ready = 1'b0;
        chk("stall_rel_ov", 64'(b32.out_valid), 64'd0);
        chk("stall_rel_rdy", 64'(b32.in_ready), 64'd1);
        chk("stall_rel_busy", 64'(busy32), 64'd0);
        @(negedge clk);
        chk("stall_no_queue", 64'(busy32), 64'd0);

        // Reset in the middle of SHIFT, cycle 20.
        b32.in_x     = 32'd1234;
        b32.in_y     = 32'd5678;
        b32.in_valid = 1'b1;
        @(negedge clk);
        b32.in_valid = 1'b0;
        repeat (20) @(negedge clk);
        chk("mid_busy", 64'(busy32), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_spm_rst", 64'(srst32), 64'd1);
        chk("mid_in_ready", 64'(b32.in_ready), 64'd1);
        chk("mid_busy_clr", 64'(busy32), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        op32(32'd2, 32'd9, pv, lat, bc);
        chk("after_rst_p", pv, 64'd18);
        chk("after_rst_lat", 64'(lat), 64'd65);

        // SIZE=4 random back-to-back.
        for (int i = 0; i < 500; i++) begin
            logic [3:0] rx;
            logic [3:0] ry;
            logic [7:0] ep;
            int         a;
            int         b;
            rx = 4'($urandom_range(0, 15));
            ry = 4'($urandom_range(0, 15));
            a  = int'($signed(rx));
            b  = int'($signed(ry));
            ep = 8'(a * b);
            b4.in_x     = rx;
            b4.in_y     = ry;
            b4.in_valid = 1'b1;
            @(negedge clk);
            b4.in_valid = 1'b0;
            n = 0;
            while (!b4.out_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("r4_%0d_lat", i), 64'(n), 64'd9);
            chk($sformatf("r4_%0d_p x=%h y=%h", i, rx, ry),
                64'(b4.out_p), 64'(ep));
            b4.out_ready = 1'b1;
            @(negedge clk);
            b4.out_ready = 1'b0;
            chk($sformatf("r4_%0d_rdy", i), 64'(b4.in_ready), 64'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
